// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ACC  = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_RESP = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DBG  = 2'b10
   } arb_owner_t;

   localparam int LAT_CNT_W    = 4;
   localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/arb_req_latch.sv
// Captures the granted port's we/addr/wdata and presents them on the memory bus.
module arb_req_latch
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_sel_dbg,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   input  logic          i_dbg_we,
   input  logic [AW-1:0] i_dbg_addr,
   input  logic [DW-1:0] i_dbg_wdata,
   input  logic          i_mem_en,
   output logic          o_req_we,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata
);

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (i_load) begin
         r_we    <= i_sel_dbg ? i_dbg_we    : i_cpu_we;
         r_addr  <= i_sel_dbg ? i_dbg_addr  : i_cpu_addr;
         r_wdata <= i_sel_dbg ? i_dbg_wdata : i_cpu_wdata;
      end
   end

   assign o_req_we    = r_we;
   // Address/data hold between accesses; only the write strobe is gated.
   assign o_mem_we    = r_we & i_mem_en;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/debug arbiter for the single-port unified memory of the multicycle MIPS core.
// Define MEM_ARB_DBG_HALT_EN to add the dbg_halt input that masks CPU requests.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          reset,
`ifdef MEM_ARB_DBG_HALT_EN
   input  logic          dbg_halt,
`endif
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner,
   output logic [1:0]    stateshow
);

   localparam logic [LAT_CNT_W-1:0]    LAT_LOAD = (MEM_LAT > 1) ? LAT_CNT_W'(MEM_LAT - 2) : '0;
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   arb_state_t                r_state, w_state_next;
   arb_owner_t                r_owner, w_owner_next;
   logic [LAT_CNT_W-1:0]      r_lat_cnt, w_lat_cnt_next;
   logic [STARVE_CNT_W-1:0]   r_starve, w_starve_next;
   logic [DW-1:0]             r_cpu_rdata, r_dbg_rdata;

   logic w_halt;
   logic w_cpu_req;
   logic w_any_req;
   logic w_grant_dbg;
   logic w_load;
   logic w_req_we;
   logic w_resp_rd;

`ifdef MEM_ARB_DBG_HALT_EN
   assign w_halt = dbg_halt;
`else
   assign w_halt = 1'b0;
`endif

   assign w_cpu_req   = cpu_req & ~w_halt;
   assign w_any_req   = w_cpu_req | dbg_req;
   // Debug wins when it is alone, or when it has lost STARVE_MAX times in a row.
   assign w_grant_dbg = dbg_req & (~w_cpu_req | (r_starve == STARVE_LIM));
   assign w_load      = (r_state == ARB_IDLE) & w_any_req;

   always_comb begin
      w_state_next   = r_state;
      w_owner_next   = r_owner;
      w_lat_cnt_next = r_lat_cnt;
      w_starve_next  = r_starve;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_req) begin
               w_state_next = ARB_ACC;
               if (w_grant_dbg) begin
                  w_owner_next  = OWN_DBG;
                  w_starve_next = '0;
               end else begin
                  w_owner_next = OWN_CPU;
                  if (dbg_req && (r_starve != STARVE_LIM))
                     w_starve_next = r_starve + 1'b1;
               end
            end
         end
         ARB_ACC: begin
            w_lat_cnt_next = LAT_LOAD;
            w_state_next   = (MEM_LAT == 1) ? ARB_RESP : ARB_WAIT;
         end
         ARB_WAIT: begin
            if (r_lat_cnt == '0)
               w_state_next = ARB_RESP;
            else
               w_lat_cnt_next = r_lat_cnt - 1'b1;
         end
         ARB_RESP: begin
            w_state_next = ARB_IDLE;
            w_owner_next = OWN_NONE;
         end
         default: begin
            w_state_next = ARB_IDLE;
            w_owner_next = OWN_NONE;
         end
      endcase
      if (w_halt)
         w_starve_next = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ARB_IDLE;
         r_owner   <= OWN_NONE;
         r_lat_cnt <= '0;
         r_starve  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_owner   <= w_owner_next;
         r_lat_cnt <= w_lat_cnt_next;
         r_starve  <= w_starve_next;
      end
   end

   assign w_resp_rd = (r_state == ARB_RESP) & ~w_req_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else if (w_resp_rd) begin
         if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
         if (r_owner == OWN_DBG) r_dbg_rdata <= mem_rdata;
      end
   end

   arb_req_latch #(
      .AW (AW),
      .DW (DW)
   ) u_req_latch (
      .clk         (clk),
      .rst_n       (reset),
      .i_load      (w_load),
      .i_sel_dbg   (w_grant_dbg),
      .i_cpu_we    (cpu_we),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .i_dbg_we    (dbg_we),
      .i_dbg_addr  (dbg_addr),
      .i_dbg_wdata (dbg_wdata),
      .i_mem_en    (mem_en),
      .o_req_we    (w_req_we),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata)
   );

   assign mem_en    = (r_state == ARB_ACC);
   assign cpu_ready = (r_state == ARB_RESP) & (r_owner == OWN_CPU);
   assign dbg_ready = (r_state == ARB_RESP) & (r_owner == OWN_DBG);
   // Read data is forwarded straight from memory in the response cycle.
   assign cpu_rdata = (w_resp_rd && r_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
   assign dbg_rdata = (w_resp_rd && r_owner == OWN_DBG) ? mem_rdata : r_dbg_rdata;
   assign owner     = r_owner;
   assign stateshow = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 uses MEM_LAT=1/STARVE_MAX=2, instance 1 MEM_LAT=3/STARVE_MAX=8.
// The halt scenario runs only when MEM_ARB_DBG_HALT_EN is defined.
module tb_mem_arbiter;

   typedef struct {
      int          inst;
      int          port;
      bit          rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  cpu_req, cpu_we, dbg_req, dbg_we;
   logic [1:0]  cpu_ready, dbg_ready, mem_en, mem_we;
   logic [31:0] cpu_addr [2];
   logic [31:0] cpu_wdata [2];
   logic [31:0] cpu_rdata [2];
   logic [31:0] dbg_addr [2];
   logic [31:0] dbg_wdata [2];
   logic [31:0] dbg_rdata [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic [1:0]  owner [2];
   logic [1:0]  stateshow [2];
`ifdef MEM_ARB_DBG_HALT_EN
   logic [1:0]  dbg_halt;
`endif

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT  = (gi == 0) ? 1 : 3;
      localparam int SMAX = (gi == 0) ? 2 : 8;
      logic [31:0] mem [0:255];
      logic [31:0] pipe [0:2];

      mem_arbiter #(
         .AW (32), .DW (32), .MEM_LAT (LAT), .STARVE_MAX (SMAX)
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n),
`ifdef MEM_ARB_DBG_HALT_EN
         .dbg_halt  (dbg_halt[gi]),
`endif
         .cpu_req   (cpu_req[gi]),
         .cpu_we    (cpu_we[gi]),
         .cpu_addr  (cpu_addr[gi]),
         .cpu_wdata (cpu_wdata[gi]),
         .cpu_rdata (cpu_rdata[gi]),
         .cpu_ready (cpu_ready[gi]),
         .dbg_req   (dbg_req[gi]),
         .dbg_we    (dbg_we[gi]),
         .dbg_addr  (dbg_addr[gi]),
         .dbg_wdata (dbg_wdata[gi]),
         .dbg_rdata (dbg_rdata[gi]),
         .dbg_ready (dbg_ready[gi]),
         .mem_en    (mem_en[gi]),
         .mem_we    (mem_we[gi]),
         .mem_addr  (mem_addr[gi]),
         .mem_wdata (mem_wdata[gi]),
         .mem_rdata (mem_rdata[gi]),
         .owner     (owner[gi]),
         .stateshow (stateshow[gi])
      );

      // Memory model: word 0x10 (byte 0x40) holds DEADBEEF, others C0DE0000|index.
      always @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < 256; i++)
               mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | i);
         end else if (mem_en[gi] && mem_we[gi]) begin
            mem[mem_addr[gi][9:2]] <= mem_wdata[gi];
         end
         if (mem_en[gi]) pipe[0] <= mem[mem_addr[gi][9:2]];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign mem_rdata[gi] = pipe[LAT-1];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int inst, input int port, input bit rd, input logic [31:0] data, input int at);
      exp_t e;
      e.inst = inst; e.port = port; e.rd = rd; e.data = data; e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_resp(input int k, input int port, input logic [31:0] rdata);
      exp_t e;
      $display("resp inst=%0d port=%0d cycle=%0d rdata=0x%h", k, port, cyc, rdata);
      if (exp_q.size() == 0) begin
         chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("resp_inst", k, e.inst);
         chk("resp_port", port, e.port);
         chk("resp_cycle", cyc, e.cyc);
         if (e.rd) chk("resp_rdata", rdata, e.data);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
               if (cpu_ready[k]) check_resp(k, 0, cpu_rdata[k]);
               if (dbg_ready[k]) check_resp(k, 1, dbg_rdata[k]);
            end
         end
      end
   endtask

   task automatic drive_cpu(input int k, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
   endtask

   task automatic drive_dbg(input int k, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      dbg_req[k] = req; dbg_we[k] = we; dbg_addr[k] = addr; dbg_wdata[k] = wd;
   endtask

   initial begin
      int c;
      logic [1:0] own_seq [6];
      own_seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_cpu(k, 1'b0, 1'b0, 32'h0, 32'h0);
         drive_dbg(k, 1'b0, 1'b0, 32'h0, 32'h0);
      end
`ifdef MEM_ARB_DBG_HALT_EN
      dbg_halt = 2'b00;
`endif
      fork
         monitor();
      join_none
      tick(3);

      // Reset state
      for (int k = 0; k < 2; k++) begin
         chk("rst_owner", owner[k], 2'b00);
         chk("rst_state", stateshow[k], 2'b00);
         chk("rst_mem_en", mem_en[k], 1'b0);
         chk("rst_mem_we", mem_we[k], 1'b0);
         chk("rst_ready", {cpu_ready[k], dbg_ready[k]}, 2'b00);
         chk("rst_mem_addr", mem_addr[k], 32'h0);
         chk("rst_cpu_rdata", cpu_rdata[k], 32'h0);
      end
      rst_n = 1'b1;
      tick(1);

      // 1: CPU read, MEM_LAT=1
      c = cyc;
      drive_cpu(0, 1'b1, 1'b0, 32'h40, 32'h0);
      push(0, 0, 1'b1, 32'hDEADBEEF, c + 2);
      tick(1);
      chk("t1_mem_en", mem_en[0], 1'b1);
      chk("t1_mem_addr", mem_addr[0], 32'h40);
      chk("t1_mem_we", mem_we[0], 1'b0);
      chk("t1_owner", owner[0], 2'b01);
      tick(1);
      chk("t1_dbg_ready", dbg_ready[0], 1'b0);
      cpu_req[0] = 1'b0;
      tick(2);
      chk("t1_rdata_hold", cpu_rdata[0], 32'hDEADBEEF);
      chk("t1_ready_low", cpu_ready[0], 1'b0);

      // 2: simultaneous requests, CPU first then debug
      c = cyc;
      drive_cpu(0, 1'b1, 1'b0, 32'h44, 32'h0);
      drive_dbg(0, 1'b1, 1'b0, 32'h48, 32'h0);
      push(0, 0, 1'b1, 32'hC0DE0011, c + 2);
      push(0, 1, 1'b1, 32'hC0DE0012, c + 5);
      tick(2);
      cpu_req[0] = 1'b0;
      tick(2);
      chk("t2_dbg_mem_en", mem_en[0], 1'b1);
      chk("t2_dbg_addr", mem_addr[0], 32'h48);
      chk("t2_dbg_owner", owner[0], 2'b10);
      tick(1);
      dbg_req[0] = 1'b0;
      tick(1);

      // 3: starvation limit 2 with both requests held
      c = cyc;
      drive_cpu(0, 1'b1, 1'b0, 32'h40, 32'h0);
      drive_dbg(0, 1'b1, 1'b0, 32'h44, 32'h0);
      for (int g = 0; g < 6; g++) begin
         if (own_seq[g] == 2'b01) push(0, 0, 1'b1, 32'hDEADBEEF, c + 3*g + 2);
         else                     push(0, 1, 1'b1, 32'hC0DE0011, c + 3*g + 2);
      end
      for (int g = 0; g < 6; g++) begin
         tick(1);
         chk("t3_owner", owner[0], own_seq[g]);
         tick(1);
         if (g == 5) begin
            cpu_req[0] = 1'b0;
            dbg_req[0] = 1'b0;
         end
         tick(1);
      end

      // 4: debug write with MEM_LAT=3, then read back
      c = cyc;
      drive_dbg(1, 1'b1, 1'b1, 32'h100, 32'h12345678);
      push(1, 1, 1'b0, 32'h0, c + 4);
      tick(1);
      chk("t4_mem_en", mem_en[1], 1'b1);
      chk("t4_mem_we", mem_we[1], 1'b1);
      chk("t4_mem_addr", mem_addr[1], 32'h100);
      chk("t4_mem_wdata", mem_wdata[1], 32'h12345678);
      for (int i = 0; i < 2; i++) begin
         tick(1);
         chk("t4_wait_en", {mem_en[1], mem_we[1]}, 2'b00);
         chk("t4_addr_hold", mem_addr[1], 32'h100);
      end
      tick(1);
      chk("t4_dbg_rdata_wr", dbg_rdata[1], 32'h0);
      dbg_req[1] = 1'b0;
      tick(1);
      c = cyc;
      drive_dbg(1, 1'b1, 1'b0, 32'h100, 32'h0);
      push(1, 1, 1'b1, 32'h12345678, c + 4);
      tick(4);
      dbg_req[1] = 1'b0;
      tick(1);
      chk("t4_rdata_hold", dbg_rdata[1], 32'h12345678);

      // 5: asynchronous reset during WAIT
      c = cyc;
      drive_cpu(1, 1'b1, 1'b0, 32'h44, 32'h0);
      tick(2);
      chk("t5_pre_state", stateshow[1], 2'b10);
      chk("t5_pre_owner", owner[1], 2'b01);
      #2 rst_n = 1'b0;
      cpu_req[1] = 1'b0;
      #1;
      chk("t5_owner", owner[1], 2'b00);
      chk("t5_state", stateshow[1], 2'b00);
      chk("t5_mem_en", mem_en[1], 1'b0);
      chk("t5_ready", {cpu_ready[1], dbg_ready[1]}, 2'b00);
      chk("t5_mem_addr", mem_addr[1], 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      c = cyc;
      drive_cpu(1, 1'b1, 1'b0, 32'h40, 32'h0);
      push(1, 0, 1'b1, 32'hDEADBEEF, c + 4);
      tick(4);
      cpu_req[1] = 1'b0;
      tick(1);

`ifdef MEM_ARB_DBG_HALT_EN
      // 6: dbg_halt masks the CPU while debug is still served
      c = cyc;
      dbg_halt[0] = 1'b1;
      drive_cpu(0, 1'b1, 1'b0, 32'h40, 32'h0);
      tick(1);
      chk("t6_no_grant", owner[0], 2'b00);
      chk("t6_no_en", mem_en[0], 1'b0);
      tick(1);
      drive_dbg(0, 1'b1, 1'b0, 32'h48, 32'h0);
      push(0, 1, 1'b1, 32'hC0DE0012, c + 4);
      tick(1);
      chk("t6_dbg_owner", owner[0], 2'b10);
      tick(1);
      dbg_req[0] = 1'b0;
      tick(3);
      chk("t6_still_halted", owner[0], 2'b00);
      tick(3);
      dbg_halt[0] = 1'b0;
      push(0, 0, 1'b1, 32'hDEADBEEF, c + 12);
      tick(2);
      cpu_req[0] = 1'b0;
      tick(1);
`endif

      tick(4);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single-port unified instruction/data memory of the multicycle MIPS core between two requesters. Port 0 is the CPU, driven by the main decoder's memory-access states (fetch, load, store). Port 1 is the debug/loader port, used for program load and memory inspection. The block sequences each access through a fixed-latency memory and returns a one-cycle ready pulse, which stalls the CPU FSM until its access completes.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
STARVE_MAX, 8, number of arbitrations debug may lose in a row before it is forced to win; legal range 1..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
cpu_req  in  1  CPU access request; held until cpu_ready
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data
cpu_ready  out  1  one-cycle completion pulse to the CPU
dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/AW/DW  debug request fields, same rules as the CPU fields
dbg_rdata  out  DW  debug read data
dbg_ready  out  1  one-cycle completion pulse to debug
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
owner  out  2  current owner: 00 none, 01 CPU, 10 debug
stateshow  out  2  current FSM state, for the board display

Behaviour:
- States: ARB_IDLE, ARB_ACC, ARB_WAIT, ARB_RESP.
- Reset values:
  - state = ARB_IDLE, owner = 00.
  - mem_en, mem_we, both ready outputs = 0.
  - mem_addr, mem_wdata, both rdata hold registers, and the starve counter = 0.
- Reset mid-access: the in-flight access is abandoned and mem_en drops immediately (asynchronous). No ready pulse is issued for it.
- ARB_IDLE: requests are sampled here.
  - If neither port requests, stay in ARB_IDLE.
  - Otherwise the winner is decided, its we/addr/wdata are latched into the request register, owner is set, and the FSM goes to ARB_ACC.
  - Winner selection: CPU wins, unless dbg_req=1 and the starve counter equals STARVE_MAX.
  - The starve counter increments when dbg_req=1 and CPU wins. It clears when debug wins. It saturates at STARVE_MAX.
- ARB_ACC: lasts exactly one cycle.
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request.
  - Goes to ARB_RESP if MEM_LAT=1, else to ARB_WAIT.
- ARB_WAIT: lasts MEM_LAT-1 cycles, timed by a 4-bit down-counter. mem_en=0. Then goes to ARB_RESP.
- ARB_RESP: lasts one cycle.
  - The owner's ready=1.
  - For a read, the owner's rdata equals mem_rdata in this cycle and is captured into that port's hold register.
  - For a write, rdata keeps its held value.
  - The non-owner's ready and rdata are unaffected.
  - Goes to ARB_IDLE; owner returns to 00.
- Latency: the request is sampled in IDLE cycle c, mem_en is high in cycle c+1, and ready is high in cycle c+1+MEM_LAT.
  - There is always one IDLE cycle between accesses.
- Handshake rules:
  - Requester inputs are ignored once latched.
  - A requester must drop req in the cycle after ready. A req still high in the following IDLE cycle counts as a new request.
- Both requests in the same cycle: resolved by the priority rule. The loser's request stays pending and is served after the winner's RESP (next IDLE).
- mem_* outputs hold their last values outside ARB_ACC. mem_we is qualified by mem_en.

Optional Feature:
Macro MEM_ARB_DBG_HALT_EN.
- Defined:
  - Adds input port dbg_halt (1 bit).
  - While dbg_halt=1 in ARB_IDLE, cpu_req is masked; the CPU stalls with no ready.
  - An access already granted completes normally.
  - The starve counter is held at 0 while halted.
- Not defined:
  - The dbg_halt port does not exist.
  - Arbitration follows the base priority rule only.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_ACC, ARB_WAIT, ARB_RESP}
  - enum arb_owner_t {OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_DBG=2'b10}
  - localparam LAT_CNT_W = 4
- Sub-module arb_req_latch: a single instance captures the selected port's we/addr/wdata on grant and drives mem_we/mem_addr/mem_wdata. The FSM, counters and rdata hold registers stay in mem_arbiter.

Test Plan:
1. MEM_LAT=1; CPU read at addr 0x40, memory returns 0xDEADBEEF; req sampled in cycle 0 → mem_en=1, addr 0x40, we=0 in cycle 1; cpu_ready=1 with cpu_rdata=0xDEADBEEF in cycle 2; dbg_ready stays 0; cpu_rdata holds 0xDEADBEEF afterwards.
2. cpu_req and dbg_req both rise in cycle 0 → CPU served with ready in cycle 2; debug sampled in cycle 3, mem_en in cycle 4, dbg_ready in cycle 5.
3. STARVE_MAX=2; both requests re-asserted continuously → grant order CPU, CPU, DBG, CPU, CPU, DBG; owner output matches this order.
4. MEM_LAT=3; debug write of 0x12345678 to 0x100 → mem_en/mem_we high for one cycle only, with that addr and data; dbg_ready high exactly 4 cycles after the sample cycle; dbg_rdata unchanged.
5. reset driven to 0 during ARB_WAIT → mem_en, owner, both ready outputs and stateshow go to 0 without waiting for a clock edge; after release, a new CPU read completes normally.
6. MEM_ARB_DBG_HALT_EN defined; dbg_halt=1 and cpu_req=1 for 10 cycles → no CPU grant; a debug read completes meanwhile; on dbg_halt=0 the CPU is granted at the next IDLE.
